psc_ctrl: RTL and testbench

//  Run-time controller for the board prescaler. Replaces the fixed free-running divider.

---
 rtl/psc_ctrl.sv | 166 ++++++++++++++++
 tb/tb_psc_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psc_ctrl.sv
// psc_ctrl -- run-time controller for the board prescaler.
// Sequences a programmable divide counter on CLK100MHZ. It supports start/stop,
// periodic or one-shot mode, and glitch-free divisor reload through a
// valid/ready config port. It emits a 1-cycle tick enable and a registered
// divided square wave.
//
// Ports:
//   CLK100MHZ    in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   cfg_valid    in   config request
//   cfg_ready    out  config accepted when cfg_valid & cfg_ready at an edge
//   cfg_div      in   requested divisor (legal 2 .. 2**CNT_W-1)
//   cfg_oneshot  in   requested mode (1 = one-shot)
//   start        in   level-sampled run request
//   stop         in   level-sampled halt request
//   tick         out  1-cycle pulse once per divided period
//   div_clk      out  registered divided square wave
//   busy         out  1 while running
//   done         out  1 while a one-shot run has finished
//   err          out  1-cycle pulse when a config with cfg_div < 2 is rejected
//   cnt          out  current count (debug)
//
// state | meaning
// IDLE  | stopped, counter held at 0, config applied directly
// RUN   | counting; config goes to a shadow register applied at the next wrap
// DONE  | one-shot period finished, waiting for start or a new config
module psc_ctrl #(
    parameter int CNT_W   = 14,
    parameter int DEF_DIV = 10000,
    parameter bit DEF_OS  = 1'b0
) (
    input  logic             CLK100MHZ,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_oneshot,
    input  logic             start,
    input  logic             stop,
    output logic             tick,
    output logic             div_clk,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] cnt
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] div_reg, div_nxt;
    logic [CNT_W-1:0] sh_div, sh_div_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             os_reg, os_nxt;
    logic             sh_os, sh_os_nxt;
    logic             sh_full, sh_full_nxt;
    logic             tick_nxt, div_clk_nxt, err_nxt;
    logic             accept, cfg_ok, wrap;

    assign cfg_ready = (state != RUN) || !sh_full;
    assign accept    = cfg_valid & cfg_ready;
    assign cfg_ok    = (cfg_div >= TWO);
    assign wrap      = (cnt == div_reg - ONE);

    always_comb begin
        state_nxt   = state;
        div_nxt     = div_reg;
        os_nxt      = os_reg;
        sh_div_nxt  = sh_div;
        sh_os_nxt   = sh_os;
        sh_full_nxt = sh_full;
        cnt_nxt     = cnt;
        tick_nxt    = 1'b0;
        div_clk_nxt = 1'b0;
        err_nxt     = accept & ~cfg_ok;

        case (state)
            IDLE, DONE: begin
                cnt_nxt = '0;
                if (accept && cfg_ok) begin
                    div_nxt   = cfg_div;
                    os_nxt    = cfg_oneshot;
                    state_nxt = IDLE;
                end
                if (start)
                    state_nxt = RUN;
            end
            RUN: begin
                if (stop) begin
                    // stop beats wrap and start; pending config must not be lost
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    if (sh_full) begin
                        div_nxt     = sh_div;
                        os_nxt      = sh_os;
                        sh_full_nxt = 1'b0;
                    end
                    if (accept && cfg_ok) begin
                        div_nxt = cfg_div;
                        os_nxt  = cfg_oneshot;
                    end
                end else if (wrap) begin
                    cnt_nxt  = '0;
                    tick_nxt = 1'b1;
                    // mode in force for the finishing period decides one-shot
                    if (os_reg)
                        state_nxt = DONE;
                    if (sh_full) begin
                        div_nxt     = sh_div;
                        os_nxt      = sh_os;
                        sh_full_nxt = 1'b0;
                    end
                    // an accept on the wrap edge waits for the following wrap
                    if (accept && cfg_ok) begin
                        sh_div_nxt  = cfg_div;
                        sh_os_nxt   = cfg_oneshot;
                        sh_full_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt     = cnt + ONE;
                    div_clk_nxt = ((cnt + ONE) >= (div_reg >> 1));
                    if (accept && cfg_ok) begin
                        sh_div_nxt  = cfg_div;
                        sh_os_nxt   = cfg_oneshot;
                        sh_full_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div_reg <= CNT_W'(DEF_DIV);
            os_reg  <= DEF_OS;
            sh_div  <= '0;
            sh_os   <= 1'b0;
            sh_full <= 1'b0;
            cnt     <= '0;
            tick    <= 1'b0;
            div_clk <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            div_reg <= div_nxt;
            os_reg  <= os_nxt;
            sh_div  <= sh_div_nxt;
            sh_os   <= sh_os_nxt;
            sh_full <= sh_full_nxt;
            cnt     <= cnt_nxt;
            tick    <= tick_nxt;
            div_clk <= div_clk_nxt;
            busy    <= (state_nxt == RUN);
            done    <= (state_nxt == DONE);
            err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_psc_ctrl.sv
// Testbench for psc_ctrl (CNT_W=8, DEF_DIV=4): directed scenarios with literal
// expectations, then random stimulus checked every cycle against a behavioural model.
module tb_psc_ctrl;

    localparam int CNT_W = 8;

    logic             CLK100MHZ = 1'b0;
    logic             rst_n     = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_div   = '0;
    logic             cfg_oneshot = 1'b0;
    logic             start = 1'b0;
    logic             stop  = 1'b0;
    logic             tick, div_clk, busy, done, err;
    logic [CNT_W-1:0] cnt;

    always #5 CLK100MHZ = ~CLK100MHZ;

    psc_ctrl #(.CNT_W(CNT_W), .DEF_DIV(4), .DEF_OS(1'b0)) dut (
        .CLK100MHZ  (CLK100MHZ),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_div    (cfg_div),
        .cfg_oneshot(cfg_oneshot),
        .start      (start),
        .stop       (stop),
        .tick       (tick),
        .div_clk    (div_clk),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cnt        (cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // behavioural model: mode 0 idle, 1 running, 2 finished
    int m_mode, m_div, m_os, m_cnt;
    int m_tick, m_dclk, m_err;
    int sh_div_q[$];
    int sh_os_q[$];

    function automatic int m_ready();
        return ((m_mode != 1) || (sh_div_q.size() == 0)) ? 1 : 0;
    endfunction

    task automatic m_reset();
        m_mode = 0; m_div = 4; m_os = 0; m_cnt = 0;
        m_tick = 0; m_dclk = 0; m_err = 0;
        sh_div_q.delete();
        sh_os_q.delete();
    endtask

    task automatic m_apply_pending();
        if (sh_div_q.size() != 0) begin
            m_div = sh_div_q.pop_front();
            m_os  = sh_os_q.pop_front();
        end
    endtask

    // one rising edge worth of rules, using the inputs present at that edge
    task automatic m_step();
        int  cd;
        int  co;
        bit  acc, good;
        int  old_os;
        cd   = int'(cfg_div);
        co   = int'(cfg_oneshot);
        acc  = cfg_valid && (m_ready() == 1);
        good = acc && (cd >= 2);
        m_err  = (acc && !good) ? 1 : 0;
        m_tick = 0;
        m_dclk = 0;
        if (m_mode != 1) begin
            m_cnt = 0;
            if (good) begin
                m_div = cd; m_os = co; m_mode = 0;
            end
            if (start) m_mode = 1;
        end else if (stop) begin
            m_mode = 0;
            m_cnt  = 0;
            m_apply_pending();
            if (good) begin
                m_div = cd; m_os = co;
            end
        end else if (m_cnt + 1 == m_div) begin
            m_tick = 1;
            m_cnt  = 0;
            old_os = m_os;
            m_apply_pending();
            if (good) begin
                sh_div_q.push_back(cd); sh_os_q.push_back(co);
            end
            if (old_os == 1) m_mode = 2;
        end else begin
            m_cnt  = m_cnt + 1;
            m_dclk = (m_cnt >= m_div / 2) ? 1 : 0;
            if (good) begin
                sh_div_q.push_back(cd); sh_os_q.push_back(co);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK100MHZ);
            if (chk_en) begin
                chk("cnt",       int'(cnt),       m_cnt);
                chk("tick",      int'(tick),      m_tick);
                chk("div_clk",   int'(div_clk),   m_dclk);
                chk("busy",      int'(busy),      (m_mode == 1) ? 1 : 0);
                chk("done",      int'(done),      (m_mode == 2) ? 1 : 0);
                chk("err",       int'(err),       m_err);
                chk("cfg_ready", int'(cfg_ready), m_ready());
            end
        end
    end

    task automatic edge_();
        @(posedge CLK100MHZ);
        if (rst_n) m_step();
        #2;
    endtask

    task automatic cfg_once(input int d, input bit os);
        cfg_valid = 1'b1; cfg_div = CNT_W'(d); cfg_oneshot = os;
        edge_();
        cfg_valid = 1'b0; cfg_oneshot = 1'b0;
    endtask

    task automatic start_once();
        start = 1'b1;
        edge_();
        start = 1'b0;
    endtask

    task automatic stop_once();
        stop = 1'b1;
        edge_();
        stop = 1'b0;
    endtask

    int nt;

    initial begin
        m_reset();
        #12;
        chk("rst_cnt",   int'(cnt), 0);
        chk("rst_ready", int'(cfg_ready), 1);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_tick",  int'(tick), 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // 1: periodic div 4
        start_once();
        chk("t1_busy", int'(busy), 1);
        for (int k = 1; k <= 12; k++) begin
            edge_();
            chk("t1_tick", int'(tick),    (k % 4 == 0) ? 1 : 0);
            chk("t1_dclk", int'(div_clk), (k % 4 >= 2) ? 1 : 0);
        end

        // 2: reload to 6 mid-period
        stop_once();
        start_once();
        edge_();
        cfg_valid = 1'b1; cfg_div = 8'd6;
        edge_();
        cfg_valid = 1'b0;
        for (int k = 3; k <= 16; k++) begin
            edge_();
            chk("t2_tick", int'(tick), (k == 4 || k == 10 || k == 16) ? 1 : 0);
            if (k == 3) chk("t2_ready_lo", int'(cfg_ready), 0);
            if (k == 5) chk("t2_ready_hi", int'(cfg_ready), 1);
        end

        // 3: one-shot div 5
        stop_once();
        cfg_once(5, 1'b1);
        start_once();
        nt = 0;
        for (int k = 1; k <= 10; k++) begin
            edge_();
            nt += int'(tick);
            if (k == 4) chk("t3_busy_run", int'(busy), 1);
            if (k == 5) begin
                chk("t3_tick", int'(tick), 1);
                chk("t3_busy", int'(busy), 0);
                chk("t3_done", int'(done), 1);
            end
            if (k >= 5) chk("t3_dclk", int'(div_clk), 0);
        end
        chk("t3_ntick", nt, 1);

        // 4: stop at terminal count, start+stop together
        cfg_once(4, 1'b0);
        chk("t4_done_clr", int'(done), 0);
        start_once();
        edge_(); edge_(); edge_();
        chk("t4_cnt3", int'(cnt), 3);
        stop_once();
        chk("t4_tick", int'(tick), 0);
        chk("t4_busy", int'(busy), 0);
        chk("t4_cnt",  int'(cnt), 0);
        start_once();
        start = 1'b1; stop = 1'b1;
        edge_();
        start = 1'b0; stop = 1'b0;
        chk("t4_ss_busy", int'(busy), 0);

        // 5: rejected divisor, then max divisor
        cfg_once(1, 1'b0);
        chk("t5_err", int'(err), 1);
        edge_();
        chk("t5_err_clr", int'(err), 0);
        start_once();
        for (int k = 1; k <= 4; k++) begin
            edge_();
            chk("t5_tick4", int'(tick), (k == 4) ? 1 : 0);
        end
        stop_once();
        cfg_once(255, 1'b0);
        start_once();
        nt = 0;
        for (int k = 1; k <= 510; k++) begin
            edge_();
            nt += int'(tick);
            if (k == 254 || k == 255 || k == 509 || k == 510)
                chk("t5_tick255", int'(tick), (k == 255 || k == 510) ? 1 : 0);
        end
        chk("t5_ntick", nt, 2);

        // 6: async reset with shadow full
        stop_once();
        cfg_once(4, 1'b0);
        start_once();
        edge_();
        cfg_once(7, 1'b0);
        chk("t6_ready_lo", int'(cfg_ready), 0);
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("t6_busy",  int'(busy), 0);
        chk("t6_cnt",   int'(cnt), 0);
        chk("t6_ready", int'(cfg_ready), 1);
        chk("t6_tick",  int'(tick), 0);
        chk("t6_dclk",  int'(div_clk), 0);
        #4;
        rst_n = 1'b1;
        start_once();
        for (int k = 1; k <= 8; k++) begin
            edge_();
            chk("t6_tick4", int'(tick), (k % 4 == 0) ? 1 : 0);
        end

        // random phase
        for (int i = 0; i < 3000; i++) begin
            start       = ($urandom_range(0, 19) == 0);
            stop        = ($urandom_range(0, 39) == 0);
            cfg_valid   = ($urandom_range(0, 14) == 0);
            cfg_div     = CNT_W'($urandom_range(0, 12));
            cfg_oneshot = ($urandom_range(0, 3) == 0);
            edge_();
        end
        start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
        edge_();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
